sisc_prog_loader: RTL and testbench

Synthesizable program loader for the SISC core: it accepts a byte stream, packs it into 32-bit instruction words and writes them into instruction memory from address 0 upward. It holds the CPU in reset until the load completes. It is the write side of the instruction memory that the core's fetch path reads, and it replaces `$readmemb` loading on hardware.

---
 rtl/sisc_prog_loader.sv | 134 +++++++++++++
 tb/tb_sisc_prog_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_prog_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words, writes them
// to instruction memory from address 0, and holds the CPU in reset until done.
// Define SISC_LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module sisc_prog_loader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                cpu_reset,
  output logic                done,
  output logic                err,
  output logic [ADDRSIZE:0]   word_cnt
);

  localparam int unsigned CW      = (ADDRSIZE + 1 > 17) ? ADDRSIZE + 1 : 17;
  localparam int unsigned MEMSIZE = 1 << ADDRSIZE;

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;

  state_t        state, state_n;
  logic [7:0]    n_hi;
  logic [15:0]   n_q;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_q;
  logic          last_q, last_n;
  logic          xfer, word_end, frame_end, in_ready_n;
  logic [CW-1:0] n_full;
`ifdef SISC_LOADER_CHKSUM_EN
  logic [7:0]    chk_q;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_n    = state;
    last_n     = last_q;
    xfer       = in_valid && in_ready;
    n_full     = CW'({n_hi, in_data});
    word_end   = (state == DATA) && xfer && (byte_cnt == 2'd3);
    frame_end  = word_end && ((CW'(word_cnt) + CW'(1)) == CW'(n_q));
    case (state)
      HDR_HI: if (xfer) state_n = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (n_full > CW'(MEMSIZE)) begin
            state_n = ERR;
          end else if (n_full == '0) begin
`ifdef SISC_LOADER_CHKSUM_EN
            state_n = CHK;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
`ifdef SISC_LOADER_CHKSUM_EN
        if (frame_end) state_n = CHK;
`else
        // final word's write strobe is still in flight; finish after it
        if (last_q) state_n = DONE;
        else if (frame_end) last_n = 1'b1;
`endif
      end
      CHK: begin
`ifdef SISC_LOADER_CHKSUM_EN
        if (xfer) state_n = (in_data == chk_q) ? DONE : ERR;
`else
        state_n = ERR;
`endif
      end
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = HDR_HI;
    endcase
    in_ready_n = ((state_n == HDR_HI) || (state_n == HDR_LO) ||
                  (state_n == DATA) || (state_n == CHK)) && !last_n;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HDR_HI;
      last_q    <= 1'b0;
      n_hi      <= '0;
      n_q       <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
`ifdef SISC_LOADER_CHKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      last_q    <= last_n;
      in_ready  <= in_ready_n;
      done      <= (state_n == DONE);
      err       <= (state_n == ERR);
      cpu_reset <= (state_n != DONE);
      mem_we    <= word_end;
      if ((state == HDR_HI) && xfer) n_hi <= in_data;
      if ((state == HDR_LO) && xfer) n_q <= {n_hi, in_data};
      if ((state == DATA) && xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_q    <= {asm_q[15:0], in_data};
      end
      if (word_end) begin
        mem_wdata <= WIDTH'({asm_q, in_data});
        mem_addr  <= word_cnt[ADDRSIZE-1:0];
        word_cnt  <= word_cnt + {{ADDRSIZE{1'b0}}, 1'b1};
      end
`ifdef SISC_LOADER_CHKSUM_EN
      if (state == HDR_HI) chk_q <= '0;
      else if ((state == DATA) && xfer) chk_q <= chk_q ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_sisc_prog_loader.sv
// Directed bench for sisc_prog_loader: table of whole frames plus hand-written
// sequences for write latency, mid-frame reset, checksum and a full-memory load.
module tb_sisc_prog_loader;

  localparam int unsigned ADDRSIZE = 12;
  localparam int unsigned MEMSIZE  = 1 << ADDRSIZE;
  localparam int          NV       = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic                cpu_reset;
  logic                done;
  logic                err;
  logic [ADDRSIZE:0]   word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [ADDRSIZE-1:0] wa[$];
  logic [31:0]         wd[$];

  typedef struct {
    int                 len;
    logic [0:13][7:0]   b;
    int                 gap;
    logic               exp_done;
    logic               exp_err;
    int                 exp_words;
    logic [0:2][31:0]   exp_w;
  } vec_t;

  vec_t vecs [NV];

  sisc_prog_loader #(.WIDTH(32), .ADDRSIZE(ADDRSIZE)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Write log of everything the loader strobes into memory
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wa.delete(); wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 for byte %0h", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h5A;
  endtask

  task automatic junk_idle();
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  x;
    logic [31:0] w;
    int          bad;

    vecs[0] = '{10, {8'h00,8'h02,8'h10,8'h00,8'h00,8'h05,8'h90,8'h00,8'h00,8'h00,{4{8'h00}}},
                0, 1'b1, 1'b0, 2, {32'h10000005, 32'h90000000, 32'h0}};
    vecs[1] = '{10, {8'h00,8'h02,8'h10,8'h00,8'h00,8'h05,8'h90,8'h00,8'h00,8'h00,{4{8'h00}}},
                1, 1'b1, 1'b0, 2, {32'h10000005, 32'h90000000, 32'h0}};
    vecs[2] = '{2, {8'h10,8'h01,{12{8'h00}}}, 0, 1'b0, 1'b1, 0, {32'h0, 32'h0, 32'h0}};
    vecs[3] = '{2, {8'h00,8'h00,{12{8'h00}}}, 0, 1'b1, 1'b0, 0, {32'h0, 32'h0, 32'h0}};
    vecs[4] = '{6, {8'h00,8'h01,8'h12,8'h34,8'h56,8'h78,{8{8'h00}}},
                0, 1'b1, 1'b0, 1, {32'h12345678, 32'h0, 32'h0}};
    vecs[5] = '{14, {8'h00,8'h03,8'h01,8'h02,8'h03,8'h04,8'hA5,8'h5A,8'hFF,8'h00,
                     8'h11,8'h22,8'h33,8'h44},
                2, 1'b1, 1'b0, 3, {32'h01020304, 32'hA55AFF00, 32'h11223344}};

    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_cnt", word_cnt, 0);

    // Whole-frame vectors
    for (int v = 0; v < NV; v++) begin
      do_reset();
      x = 8'h00;
      for (int i = 0; i < vecs[v].len; i++) begin
        repeat (vecs[v].gap) begin
          in_valid = 1'b0; in_data = 8'h5A;
          @(posedge clk); #1;
        end
        send_byte(vecs[v].b[i]);
        if (i >= 2) x = x ^ vecs[v].b[i];
      end
`ifdef SISC_LOADER_CHKSUM_EN
      if (vecs[v].exp_done) send_byte(x);
`endif
      junk_idle();
      chk($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      chk($sformatf("v%0d_cpu_reset", v), cpu_reset, !vecs[v].exp_done);
      chk($sformatf("v%0d_in_ready", v), in_ready, 0);
      chk($sformatf("v%0d_word_cnt", v), word_cnt, vecs[v].exp_words);
      chk($sformatf("v%0d_nwrites", v), wa.size(), vecs[v].exp_words);
      for (int k = 0; k < vecs[v].exp_words; k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), (k < wa.size()) ? wa[k] : 'x, k);
        chk($sformatf("v%0d_data%0d", v, k), (k < wd.size()) ? wd[k] : 'x, vecs[v].exp_w[k]);
      end
    end

    // Write latency and completion timing on a 1-word frame
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk("lat_mem_we", mem_we, 1);
    chk("lat_mem_addr", mem_addr, 0);
    chk("lat_mem_wdata", mem_wdata, 32'hAABBCCDD);
    chk("lat_word_cnt", word_cnt, 1);
    chk("lat_done_early", done, 0);
`ifdef SISC_LOADER_CHKSUM_EN
    chk("lat_in_ready_chk", in_ready, 1);
    send_byte(8'h00);
`else
    chk("lat_in_ready_drop", in_ready, 0);
    @(posedge clk); #1;
`endif
    chk("lat_done", done, 1);
    chk("lat_cpu_reset", cpu_reset, 0);
    chk("lat_mem_we_off", mem_we, 0);

    // Empty frame completes right after the header (or after a 00 checksum)
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
`ifdef SISC_LOADER_CHKSUM_EN
    chk("n0_wait_chk", done, 0);
    chk("n0_ready_chk", in_ready, 1);
    send_byte(8'h00);
`endif
    chk("n0_done", done, 1);
    chk("n0_cpu_reset", cpu_reset, 0);

    // Reset coincident with the 4th payload byte wins and drops the write
    do_reset();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    in_valid = 1'b1; in_data = 8'h04; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_mem_we", mem_we, 0);
    chk("mid_word_cnt", word_cnt, 0);
    chk("mid_in_ready", in_ready, 1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef SISC_LOADER_CHKSUM_EN
    send_byte(8'h22);
`endif
    junk_idle();
    chk("mid_nwrites", wa.size(), 1);
    chk("mid_addr", (wa.size() > 0) ? wa[0] : 'x, 0);
    chk("mid_data", (wd.size() > 0) ? wd[0] : 'x, 32'hDEADBEEF);
    chk("mid_word_cnt_end", word_cnt, 1);
    chk("mid_done", done, 1);

`ifdef SISC_LOADER_CHKSUM_EN
    // Checksum mismatch aborts even though the word was written
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    junk_idle();
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_reset", cpu_reset, 1);
    chk("bad_nwrites", wa.size(), 1);
    chk("bad_data", (wd.size() > 0) ? wd[0] : 'x, 32'h12345678);
`endif

    // Full-memory load: N = MEMSIZE, no address wrap
    do_reset();
    x = 8'h00;
    send_byte(8'(MEMSIZE >> 8)); send_byte(8'(MEMSIZE));
    for (int i = 0; i < int'(MEMSIZE); i++) begin
      w = 32'hA5000000 ^ 32'(i * 3);
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8]);
        x = x ^ w[j*8 +: 8];
      end
    end
`ifdef SISC_LOADER_CHKSUM_EN
    send_byte(x);
`endif
    junk_idle();
    chk("full_done", done, 1);
    chk("full_word_cnt", word_cnt, MEMSIZE);
    chk("full_nwrites", wa.size(), MEMSIZE);
    bad = 0;
    for (int k = 0; k < wa.size(); k++) begin
      if (wa[k] !== ADDRSIZE'(k) || wd[k] !== (32'hA5000000 ^ 32'(k * 3))) bad++;
    end
    chk("full_bad_entries", bad, 0);
    chk("full_last_addr", (wa.size() > 0) ? wa[wa.size()-1] : 'x, MEMSIZE - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
